// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch sequencer: BOOT/FETCH/EXEC with jump resolution
// Optional self-jump halt detection enabled by defining FETCH_HALT_EN.
module fetch_unit (
  input  logic       clock,
  input  logic       reset_n,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_data,
  output logic [2:0] OPCode,
  output logic [4:0] operand,
  output logic       instr_valid,
  input  logic       J,
  input  logic       JC,
  input  logic       NEQ,
  input  logic       eq,
  input  logic       stall,
  output logic [7:0] pc,
  output logic       halted
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [7:0] pc_q;
  logic [7:0] pc_next;
  logic [7:0] ir;
  logic [7:0] ir_next;
  logic [7:0] target;
  logic       taken;

  assign target    = {3'b000, ir[4:0]};
  // J wins over JC, so J and JC together always take the jump
  assign taken     = J | (JC & (eq ^ NEQ));
  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign OPCode    = ir[7:5];
  assign operand   = ir[4:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= BOOT;
      pc_q  <= 8'h00;
      ir    <= 8'h00;
    end else begin
      state <= next_state;
      pc_q  <= pc_next;
      ir    <= ir_next;
    end
  end

  // Outputs decode from state only, so reset drops imem_req without waiting for an edge
  always_comb begin
    next_state  = state;
    pc_next     = pc_q;
    ir_next     = ir;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state)
      BOOT: begin
        next_state = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_next    = imem_data;
          next_state = EXEC;
        end
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (!stall) begin
`ifdef FETCH_HALT_EN
          if (J && (target == pc_q)) begin
            next_state = HALT;
          end else begin
            pc_next    = taken ? target : pc_q + 8'd1;
            next_state = FETCH;
          end
`else
          pc_next    = taken ? target : pc_q + 8'd1;
          next_state = FETCH;
`endif
        end
      end
      HALT: begin
`ifdef FETCH_HALT_EN
        halted     = 1'b1;
        next_state = HALT;
`else
        next_state = BOOT;
`endif
      end
      default: begin
        next_state = BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit (vector table + address scoreboard)
module tb_fetch_unit;

  logic       clock;
  logic       reset_n;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic [2:0] OPCode;
  logic [4:0] operand;
  logic       instr_valid;
  logic       J, JC, NEQ, eq, stall;
  logic [7:0] pc;
  logic       halted;

  fetch_unit dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .OPCode(OPCode), .operand(operand), .instr_valid(instr_valid),
    .J(J), .JC(JC), .NEQ(NEQ), .eq(eq), .stall(stall),
    .pc(pc), .halted(halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    logic       j, jc, neq, e;
    int         stall_cycles;
    int         ack_delay;
    logic [7:0] exp_next;
  } vec_t;

  vec_t       vecs[11];
  logic [7:0] exp_q[$];
  int         tests = 0;
  int         fails = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_req();
    int cnt = 0;
    while (imem_req !== 1'b1 && cnt < 20) begin
      @(posedge clock); #1;
      cnt++;
    end
    chk("req_timeout", {7'd0, imem_req}, 8'h01);
  endtask

  task automatic do_instr(input logic [7:0] data, input logic j, input logic jc,
                          input logic neq, input logic e, input int stall_cycles,
                          input int ack_delay, input logic [7:0] exp_next);
    logic [7:0] exp_addr;
    wait_req();
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 8'h01, 8'h00);
      exp_addr = imem_addr;
    end else begin
      exp_addr = exp_q.pop_front();
    end
    chk("fetch_addr", imem_addr, exp_addr);
    chk("fetch_pc", pc, exp_addr);
    for (int i = 0; i < ack_delay; i++) begin
      imem_ack = 1'b0;
      @(posedge clock); #1;
      chk("delay_req", {7'd0, imem_req}, 8'h01);
      chk("delay_addr", imem_addr, exp_addr);
    end
    imem_ack  = 1'b1;
    imem_data = data;
    @(posedge clock); #1;
    imem_ack  = 1'b0;
    imem_data = 8'($urandom);
    chk("exec_valid", {7'd0, instr_valid}, 8'h01);
    chk("exec_req", {7'd0, imem_req}, 8'h00);
    chk("exec_opcode", {5'd0, OPCode}, {5'd0, data[7:5]});
    chk("exec_operand", {3'd0, operand}, {3'd0, data[4:0]});
    for (int i = 0; i < stall_cycles; i++) begin
      stall     = 1'b1;
      imem_ack  = 1'b1;
      imem_data = ~data;
      J = j; JC = jc; NEQ = neq; eq = e;
      @(posedge clock); #1;
      chk("stall_valid", {7'd0, instr_valid}, 8'h01);
      chk("stall_req", {7'd0, imem_req}, 8'h00);
      chk("stall_pc", pc, exp_addr);
      chk("stall_ir", {OPCode, operand}, data);
    end
    stall    = 1'b0;
    imem_ack = 1'b0;
    J = j; JC = jc; NEQ = neq; eq = e;
    exp_q.push_back(exp_next);
    @(posedge clock); #1;
    J = 1'b0; JC = 1'b0; NEQ = 1'b0; eq = 1'b0;
  endtask

  initial begin
    logic [7:0] p;
    // data, J, JC, NEQ, eq, stall cycles, ack delay, expected next fetch address
    vecs[0]  = '{8'h21, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 8'h01};
    vecs[1]  = '{8'h83, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 8'h03};
    vecs[2]  = '{8'h8A, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 8'h0A};
    vecs[3]  = '{8'h23, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 8'h03};
    vecs[4]  = '{8'h8A, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0, 8'h04};
    vecs[5]  = '{8'h46, 1'b0, 1'b1, 1'b0, 1'b1, 0, 4, 8'h06};
    vecs[6]  = '{8'h4A, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 8'h07};
    vecs[7]  = '{8'h4C, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 8'h0C};
    vecs[8]  = '{8'h50, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 8'h0D};
    vecs[9]  = '{8'h91, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 8'h11};
    vecs[10] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 8'h12};

    reset_n = 1'b0; imem_ack = 1'b0; imem_data = 8'h00;
    J = 1'b0; JC = 1'b0; NEQ = 1'b0; eq = 1'b0; stall = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req", {7'd0, imem_req}, 8'h00);
    chk("rst_valid", {7'd0, instr_valid}, 8'h00);
    chk("rst_halted", {7'd0, halted}, 8'h00);
    chk("rst_pc", pc, 8'h00);
    chk("rst_ir", {OPCode, operand}, 8'h00);
    #2 reset_n = 1'b1;
    chk("boot_req", {7'd0, imem_req}, 8'h00);
    @(posedge clock); #1;
    chk("first_req", {7'd0, imem_req}, 8'h01);
    chk("first_addr", imem_addr, 8'h00);
    exp_q.push_back(8'h00);

    for (int i = 0; i < 11; i++)
      do_instr(vecs[i].data, vecs[i].j, vecs[i].jc, vecs[i].neq, vecs[i].e,
               vecs[i].stall_cycles, vecs[i].ack_delay, vecs[i].exp_next);

    // walk pc from 1F up to FF, then confirm wrap to 00
    do_instr(8'h9F, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 8'h1F);
    p = 8'h1F;
    while (p != 8'hFF) begin
      do_instr(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, p + 8'd1);
      p = p + 8'd1;
    end
    do_instr(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 8'h00);

    // reset mid-FETCH with an ack pending
    wait_req();
    chk("pre_rst_addr", imem_addr, 8'h00);
    imem_ack  = 1'b1;
    imem_data = 8'hE7;
    reset_n   = 1'b0;
    #1;
    chk("async_req_drop", {7'd0, imem_req}, 8'h00);
    chk("async_valid", {7'd0, instr_valid}, 8'h00);
    @(posedge clock); #1;
    chk("rst_ack_ignored", {OPCode, operand}, 8'h00);
    imem_ack = 1'b0;
    #2 reset_n = 1'b1;
    exp_q.delete();
    chk("reboot_req", {7'd0, imem_req}, 8'h00);
    @(posedge clock); #1;
    chk("restart_req", {7'd0, imem_req}, 8'h01);
    chk("restart_addr", imem_addr, 8'h00);
    exp_q.push_back(8'h00);

    // self-jump at 05
    do_instr(8'h85, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 8'h05);
    do_instr(8'h85, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 8'h05);
`ifdef FETCH_HALT_EN
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      chk("halt_flag", {7'd0, halted}, 8'h01);
      chk("halt_req", {7'd0, imem_req}, 8'h00);
      chk("halt_valid", {7'd0, instr_valid}, 8'h00);
      chk("halt_pc", pc, 8'h05);
      imem_ack = 1'b1;
      @(posedge clock); #1;
    end
    imem_ack = 1'b0;
`else
    chk("nohalt_flag", {7'd0, halted}, 8'h00);
    do_instr(8'h85, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 8'h05);
    do_instr(8'h85, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 8'h05);
    chk("nohalt_flag_end", {7'd0, halted}, 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
